// File: rtl/pic_mem_port_arbiter.sv
// Round-robin arbiter sharing the pic_mem s2 port between a pixel writer (A) and a pixel reader (B).
// Optional grant/conflict statistics counters are enabled by defining PIC_MEM_ARB_STATS_EN.
module pic_mem_port_arbiter #(
  parameter int ADDR_W     = 12,
  parameter int DATA_W     = 16,
  parameter int RD_LATENCY = 1
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                a_valid,
  input  logic                a_write,
  input  logic [ADDR_W-1:0]   a_address,
  input  logic [DATA_W-1:0]   a_writedata,
  input  logic [DATA_W/8-1:0] a_byteenable,
  output logic                a_ready,
  output logic [DATA_W-1:0]   a_readdata,
  output logic                a_rvalid,
  input  logic                b_valid,
  input  logic                b_write,
  input  logic [ADDR_W-1:0]   b_address,
  input  logic [DATA_W-1:0]   b_writedata,
  input  logic [DATA_W/8-1:0] b_byteenable,
  output logic                b_ready,
  output logic [DATA_W-1:0]   b_readdata,
  output logic                b_rvalid,
`ifdef PIC_MEM_ARB_STATS_EN
  input  logic                stat_clear,
  output logic [31:0]         stat_a_grants,
  output logic [31:0]         stat_b_grants,
  output logic [31:0]         stat_conflicts,
`endif
  output logic [ADDR_W-1:0]   mem_address,
  output logic                mem_chipselect,
  output logic                mem_clken,
  output logic                mem_write,
  output logic [DATA_W-1:0]   mem_writedata,
  output logic [DATA_W/8-1:0] mem_byteenable,
  input  logic [DATA_W-1:0]   mem_readdata
);

  localparam int BE_W  = DATA_W / 8;
  localparam int DEPTH = RD_LATENCY + 1;

  typedef enum logic {GRANT_A = 1'b0, GRANT_B = 1'b1} grant_e;

  grant_e              last_grant_q, last_grant_d;
  logic                grant_a, grant_b, accept;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic                cs_q, cs_d, wr_q, wr_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic [BE_W-1:0]     be_q, be_d;
  logic [DEPTH-1:0]    tag_v_q, tag_v_d, tag_b_q, tag_b_d;
  logic                a_rvalid_q, a_rvalid_d, b_rvalid_q, b_rvalid_d;
  logic [DATA_W-1:0]   a_rdata_q, a_rdata_d, b_rdata_q, b_rdata_d;

  always_comb begin
    grant_a = a_valid & (~b_valid | (last_grant_q == GRANT_B));
    grant_b = b_valid & ~grant_a;
    a_ready = grant_a & ~reset;
    b_ready = grant_b & ~reset;
    accept  = a_ready | b_ready;

    last_grant_d = last_grant_q;
    if (a_ready)      last_grant_d = GRANT_A;
    else if (b_ready) last_grant_d = GRANT_B;

    addr_d  = addr_q;
    wdata_d = wdata_q;
    be_d    = be_q;
    cs_d    = 1'b0;
    wr_d    = 1'b0;
    if (accept) begin
      cs_d    = 1'b1;
      wr_d    = a_ready ? a_write : b_write;
      addr_d  = a_ready ? a_address : b_address;
      wdata_d = a_ready ? a_writedata : b_writedata;
      be_d    = wr_d ? (a_ready ? a_byteenable : b_byteenable) : '1;
    end

    // Tag stage DEPTH-1 lines up with mem_readdata; the result is registered one cycle later.
    tag_v_d = {tag_v_q[DEPTH-2:0], accept & ~wr_d};
    tag_b_d = {tag_b_q[DEPTH-2:0], b_ready};

    a_rvalid_d = tag_v_q[DEPTH-1] & ~tag_b_q[DEPTH-1];
    b_rvalid_d = tag_v_q[DEPTH-1] &  tag_b_q[DEPTH-1];
    a_rdata_d  = a_rvalid_d ? mem_readdata : a_rdata_q;
    b_rdata_d  = b_rvalid_d ? mem_readdata : b_rdata_q;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      last_grant_q <= GRANT_B;
      addr_q       <= '0;
      cs_q         <= 1'b0;
      wr_q         <= 1'b0;
      wdata_q      <= '0;
      be_q         <= '1;
      tag_v_q      <= '0;
      tag_b_q      <= '0;
      a_rvalid_q   <= 1'b0;
      b_rvalid_q   <= 1'b0;
      a_rdata_q    <= '0;
      b_rdata_q    <= '0;
    end else begin
      last_grant_q <= last_grant_d;
      addr_q       <= addr_d;
      cs_q         <= cs_d;
      wr_q         <= wr_d;
      wdata_q      <= wdata_d;
      be_q         <= be_d;
      tag_v_q      <= tag_v_d;
      tag_b_q      <= tag_b_d;
      a_rvalid_q   <= a_rvalid_d;
      b_rvalid_q   <= b_rvalid_d;
      a_rdata_q    <= a_rdata_d;
      b_rdata_q    <= b_rdata_d;
    end
  end

  assign mem_address    = addr_q;
  assign mem_chipselect = cs_q;
  assign mem_clken      = ~reset;
  assign mem_write      = wr_q;
  assign mem_writedata  = wdata_q;
  assign mem_byteenable = be_q;
  assign a_rvalid       = a_rvalid_q;
  assign b_rvalid       = b_rvalid_q;
  assign a_readdata     = a_rdata_q;
  assign b_readdata     = b_rdata_q;

`ifdef PIC_MEM_ARB_STATS_EN
  logic [31:0] stat_a_q, stat_a_d, stat_b_q, stat_b_d, stat_c_q, stat_c_d;

  always_comb begin
    stat_a_d = stat_a_q;
    stat_b_d = stat_b_q;
    stat_c_d = stat_c_q;
    if (stat_clear) begin
      stat_a_d = '0;
      stat_b_d = '0;
      stat_c_d = '0;
    end else begin
      if (a_ready && stat_a_q != '1)           stat_a_d = stat_a_q + 32'd1;
      if (b_ready && stat_b_q != '1)           stat_b_d = stat_b_q + 32'd1;
      if (a_valid && b_valid && stat_c_q != '1) stat_c_d = stat_c_q + 32'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      stat_a_q <= '0;
      stat_b_q <= '0;
      stat_c_q <= '0;
    end else begin
      stat_a_q <= stat_a_d;
      stat_b_q <= stat_b_d;
      stat_c_q <= stat_c_d;
    end
  end

  assign stat_a_grants  = stat_a_q;
  assign stat_b_grants  = stat_b_q;
  assign stat_conflicts = stat_c_q;
`endif

endmodule

// File: tb/tb_pic_mem_port_arbiter.sv
// Directed bench for pic_mem_port_arbiter with a behavioural s2 RAM model of latency RD_LAT.
module tb_pic_mem_port_arbiter;
  localparam int AW = 12;
  localparam int DW = 16;
  localparam int RD_LAT = 1;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic a_valid = 0, a_write = 0, b_valid = 0, b_write = 0;
  logic [AW-1:0] a_address = '0, b_address = '0;
  logic [DW-1:0] a_writedata = '0, b_writedata = '0;
  logic [1:0] a_byteenable = '0, b_byteenable = '0;
  logic a_ready, a_rvalid, b_ready, b_rvalid;
  logic [DW-1:0] a_readdata, b_readdata;
  logic [AW-1:0] mem_address;
  logic mem_chipselect, mem_clken, mem_write;
  logic [DW-1:0] mem_writedata, mem_readdata;
  logic [1:0] mem_byteenable;
`ifdef PIC_MEM_ARB_STATS_EN
  logic stat_clear = 1'b0;
  logic [31:0] stat_a_grants, stat_b_grants, stat_conflicts;
`endif

  int n_checks = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  pic_mem_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .RD_LATENCY(RD_LAT)) dut (
    .clk(clk), .reset(reset),
    .a_valid(a_valid), .a_write(a_write), .a_address(a_address), .a_writedata(a_writedata),
    .a_byteenable(a_byteenable), .a_ready(a_ready), .a_readdata(a_readdata), .a_rvalid(a_rvalid),
    .b_valid(b_valid), .b_write(b_write), .b_address(b_address), .b_writedata(b_writedata),
    .b_byteenable(b_byteenable), .b_ready(b_ready), .b_readdata(b_readdata), .b_rvalid(b_rvalid),
`ifdef PIC_MEM_ARB_STATS_EN
    .stat_clear(stat_clear), .stat_a_grants(stat_a_grants), .stat_b_grants(stat_b_grants),
    .stat_conflicts(stat_conflicts),
`endif
    .mem_address(mem_address), .mem_chipselect(mem_chipselect), .mem_clken(mem_clken),
    .mem_write(mem_write), .mem_writedata(mem_writedata), .mem_byteenable(mem_byteenable),
    .mem_readdata(mem_readdata)
  );

  // RAM model: readdata valid RD_LAT cycles after the cycle carrying the read command.
  logic [DW-1:0] ram [0:(1<<AW)-1];
  logic [DW-1:0] rd_pipe [0:RD_LAT-1];
  initial begin
    for (int i = 0; i < (1<<AW); i++) ram[i] = '0;
    for (int i = 0; i < RD_LAT; i++) rd_pipe[i] = '0;
  end
  assign mem_readdata = rd_pipe[RD_LAT-1];
  always @(posedge clk) begin
    if (mem_chipselect && mem_write) begin
      if (mem_byteenable[0]) ram[mem_address][7:0]  <= mem_writedata[7:0];
      if (mem_byteenable[1]) ram[mem_address][15:8] <= mem_writedata[15:8];
    end
    if (mem_chipselect && !mem_write) rd_pipe[0] <= ram[mem_address];
    for (int i = 1; i < RD_LAT; i++) rd_pipe[i] <= rd_pipe[i-1];
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    a_valid = 0; b_valid = 0;
  endtask

  task automatic test_reset();
    reset = 1; a_valid = 1; a_write = 1;
    tick(); tick();
    #1;
    n_checks++;
    if (a_ready !== 1'b0) begin n_fail++; $display("FAIL reset_ready got=%b exp=0", a_ready); end
    n_checks++;
    if ({mem_chipselect, mem_clken, mem_write, mem_byteenable} !== 5'b00011) begin
      n_fail++; $display("FAIL reset_mem got=%b exp=00011", {mem_chipselect, mem_clken, mem_write, mem_byteenable});
    end
    n_checks++;
    if ({a_rvalid, b_rvalid, a_readdata, b_readdata, mem_address} !== '0) begin
      n_fail++; $display("FAIL reset_outs got=%h exp=0", {a_rvalid, b_rvalid, a_readdata, b_readdata, mem_address});
    end
    idle(); reset = 0;
    tick();
    n_checks++;
    if (mem_clken !== 1'b1) begin n_fail++; $display("FAIL clken got=%b exp=1", mem_clken); end
  endtask

  task automatic test_a_burst();
    for (int i = 0; i < 4; i++) begin
      a_valid = 1; a_write = 1; a_address = AW'(i);
      a_writedata = 16'h1111 * DW'(i + 1); a_byteenable = 2'b11;
      #1;
      n_checks++;
      if (a_ready !== 1'b1) begin n_fail++; $display("FAIL burst_ready[%0d] got=%b exp=1", i, a_ready); end
      n_checks++;
      if (mem_chipselect !== (i != 0)) begin
        n_fail++; $display("FAIL burst_cs[%0d] got=%b exp=%b", i, mem_chipselect, i != 0);
      end
      tick();
    end
    idle();
    n_checks++;
    if ({mem_chipselect, mem_write, mem_address, mem_writedata} !== {2'b11, 12'h003, 16'h4444}) begin
      n_fail++; $display("FAIL burst_last got=%b/%b/%h/%h exp=1/1/003/4444", mem_chipselect, mem_write, mem_address, mem_writedata);
    end
    tick();
    n_checks++;
    if (mem_chipselect !== 1'b0) begin n_fail++; $display("FAIL burst_cs_end got=%b exp=0", mem_chipselect); end
  endtask

  task automatic test_contention();
    reset = 1; tick(); reset = 0; tick();
    a_valid = 1; b_valid = 1; a_write = 1; b_write = 1;
    a_address = 12'h100; b_address = 12'h101; a_byteenable = 2'b00; b_byteenable = 2'b00;
    for (int i = 0; i < 6; i++) begin
      #1;
      n_checks++;
      if ({a_ready, b_ready} !== ((i % 2 == 0) ? 2'b10 : 2'b01)) begin
        n_fail++; $display("FAIL contention[%0d] got a=%b b=%b exp a=%b", i, a_ready, b_ready, i % 2 == 0);
      end
      tick();
    end
    idle();
    n_checks++;
    if ({mem_chipselect, mem_write, mem_byteenable, mem_address} !== {2'b11, 2'b00, 12'h101}) begin
      n_fail++; $display("FAIL be_zero got=%b/%b/%b/%h exp=1/1/00/101", mem_chipselect, mem_write, mem_byteenable, mem_address);
    end
`ifdef PIC_MEM_ARB_STATS_EN
    n_checks++;
    if ({stat_a_grants, stat_b_grants, stat_conflicts} !== {32'd3, 32'd3, 32'd6}) begin
      n_fail++; $display("FAIL stats got=%0d/%0d/%0d exp=3/3/6", stat_a_grants, stat_b_grants, stat_conflicts);
    end
`endif
    tick();
  endtask

  task automatic test_read_latency();
    int hits, first;
    logic [DW-1:0] data;
    b_valid = 1; b_write = 0; b_address = 12'h003;
    #1;
    n_checks++;
    if (b_ready !== 1'b1) begin n_fail++; $display("FAIL rd_ready got=%b exp=1", b_ready); end
    tick(); idle();
    hits = 0; first = -1; data = '0;
    for (int c = 1; c <= 8; c++) begin
      if (b_rvalid) begin hits++; if (first < 0) begin first = c; data = b_readdata; end end
      n_checks++;
      if (a_rvalid !== 1'b0) begin n_fail++; $display("FAIL rd_a_rvalid c=%0d got=%b exp=0", c, a_rvalid); end
      tick();
    end
    n_checks++;
    if (hits !== 1 || first !== 2 + RD_LAT) begin
      n_fail++; $display("FAIL rd_latency got pulses=%0d at=%0d exp=1 at %0d", hits, first, 2 + RD_LAT);
    end
    n_checks++;
    if (data !== 16'h4444) begin n_fail++; $display("FAIL rd_data got=%h exp=4444", data); end
    n_checks++;
    if (b_readdata !== 16'h4444) begin n_fail++; $display("FAIL rd_hold got=%h exp=4444", b_readdata); end
  endtask

  task automatic test_raw_bytes();
    int hits;
    logic [DW-1:0] data;
    a_valid = 1; a_write = 1; a_address = 12'h010; a_writedata = 16'hABCD; a_byteenable = 2'b11;
    tick();
    a_writedata = 16'h00EF; a_byteenable = 2'b01;
    tick();
    a_valid = 0; b_valid = 1; b_write = 0; b_address = 12'h010;
    n_checks++;
    if ({mem_write, mem_byteenable, mem_writedata} !== {1'b1, 2'b01, 16'h00EF}) begin
      n_fail++; $display("FAIL raw_wr2 got=%b/%b/%h exp=1/01/00ef", mem_write, mem_byteenable, mem_writedata);
    end
    #1;
    n_checks++;
    if (b_ready !== 1'b1) begin n_fail++; $display("FAIL raw_ready got=%b exp=1", b_ready); end
    tick(); idle();
    n_checks++;
    if ({mem_chipselect, mem_write, mem_byteenable} !== 4'b1011) begin
      n_fail++; $display("FAIL raw_rdcmd got=%b exp=1011", {mem_chipselect, mem_write, mem_byteenable});
    end
    hits = 0; data = '0;
    for (int c = 1; c <= 8; c++) begin
      if (b_rvalid) begin hits++; data = b_readdata; end
      tick();
    end
    n_checks++;
    if (hits !== 1 || data !== 16'hABEF) begin
      n_fail++; $display("FAIL raw_data got pulses=%0d data=%h exp=1 abef", hits, data);
    end
  endtask

  task automatic test_reset_mid_read();
    int hits;
    b_valid = 1; b_write = 0; b_address = 12'h003;
    tick(); idle();
    reset = 1;
    tick();
    n_checks++;
    if ({mem_chipselect, mem_clken, mem_write, mem_byteenable, a_rvalid, b_rvalid} !== 7'b0001100) begin
      n_fail++; $display("FAIL midrst_mem got=%b exp=0001100", {mem_chipselect, mem_clken, mem_write, mem_byteenable, a_rvalid, b_rvalid});
    end
    n_checks++;
    if ({a_readdata, b_readdata, mem_address} !== '0) begin
      n_fail++; $display("FAIL midrst_data got=%h/%h/%h exp=0", a_readdata, b_readdata, mem_address);
    end
    reset = 0;
    hits = 0;
    for (int c = 0; c < 6; c++) begin
      if (b_rvalid) hits++;
      tick();
    end
    n_checks++;
    if (hits !== 0) begin n_fail++; $display("FAIL midrst_rvalid got=%0d pulses exp=0", hits); end
  endtask

`ifdef PIC_MEM_ARB_STATS_EN
  task automatic test_saturation();
    force dut.stat_a_q = 32'hFFFF_FFFF;
    #1;
    release dut.stat_a_q;
    a_valid = 1; a_write = 1; a_address = 12'h020; a_byteenable = 2'b00;
    tick();
    n_checks++;
    if (stat_a_grants !== 32'hFFFF_FFFF) begin
      n_fail++; $display("FAIL sat got=%h exp=ffffffff", stat_a_grants);
    end
    stat_clear = 1;
    tick();
    stat_clear = 0; idle();
    n_checks++;
    if ({stat_a_grants, stat_b_grants, stat_conflicts} !== '0) begin
      n_fail++; $display("FAIL clear got=%h/%h/%h exp=0", stat_a_grants, stat_b_grants, stat_conflicts);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_a_burst();
    test_contention();
    test_read_latency();
    test_raw_bytes();
    test_reset_mid_read();
`ifdef PIC_MEM_ARB_STATS_EN
    test_saturation();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end
endmodule
